player_move: RTL and testbench
==============================

PLAYER_MOVE -- requirements
Module: player_move

Interface
REQ-001: Parameter DEBOUNCE_CYCLES, default 16, is the number of consecutive stable synchronized samples needed to accept a button level change.
REQ-002: Parameter MOVE_DIV, default 4, is the number of clock cycles per movement tick.
REQ-003: Parameter STEP, default 4, is the pixels moved per tick.
REQ-004: Parameter X_MIN, default 0, is the leftmost legal p_x.
REQ-005: Parameter X_MAX, default 540, is the rightmost legal p_x.
REQ-006: Parameter X_INIT, default 270, is the p_x value after reset.
REQ-007: Port clk  input  1  is the single system clock; all state updates on its rising edge.
REQ-008: Port rst  input  1  is the reset: synchronous, active-high.
REQ-009: Port ena  input  1  is the game-running enable; low freezes movement.
REQ-010: Port btn_left  input  1  is the raw asynchronous left button, active-high.
REQ-011: Port btn_right  input  1  is the raw asynchronous right button, active-high.
REQ-012: Port p_x  output  12  is the registered player paddle left-edge x coordinate, consumed by the falling-object catch/score stage.
REQ-013: Port moving  output  1  is high while the FSM is in LEFT or RIGHT.
REQ-014: Port dir  output  1  is the last movement direction: 1 = right, 0 = left.

Function
REQ-015: Each button shall pass through a two-flop synchronizer before any other use.
REQ-016: Each synchronized button shall have its own debouncer: a counter clears whenever sync == debounced level and increments whenever they differ; when they differ and the counter equals DEBOUNCE_CYCLES-1, the debounced level takes the sync value and the counter clears.
REQ-017: A raw level held steady therefore changes the debounced level exactly 2+DEBOUNCE_CYCLES cycles after the edge; glitches shorter than DEBOUNCE_CYCLES cycles shall have no effect.
REQ-018: A free-running tick counter shall count 0..MOVE_DIV-1 and wrap; tick is high for exactly one cycle while the counter equals MOVE_DIV-1; the counter runs regardless of ena.
REQ-019: FSM states shall be IDLE, LEFT, RIGHT, with next state evaluated every cycle from the debounced levels (dl, dr).
REQ-020: FSM next state shall be: ena=0 -> IDLE; dl=1, dr=0 -> LEFT; dl=0, dr=1 -> RIGHT; both or neither -> IDLE; any state may transition directly to any other.
REQ-021: The FSM state register shall update one cycle after the debounced level changes.
REQ-022: On a tick cycle in LEFT, p_x shall become X_MIN if p_x-X_MIN < STEP, else p_x-STEP.
REQ-023: On a tick cycle in RIGHT, p_x shall become X_MAX if X_MAX-p_x < STEP, else p_x+STEP.
REQ-024: p_x shall hold in IDLE, in non-tick cycles, and whenever ena=0; it shall never leave [X_MIN, X_MAX], and the arithmetic shall not wrap at 12 bits.
REQ-025: The move decision shall use the current registered state, so a tick that coincides with a state change uses the old state.
REQ-026: moving shall be combinational from the state register; dir shall be set to 1 on entering RIGHT, set to 0 on entering LEFT, and hold in IDLE.

Reset
REQ-027: With rst=1 at a clock edge: p_x=X_INIT, state=IDLE, moving=0, dir=0, and all synchronizer flops, debounced levels, debounce counters and tick counter = 0.
REQ-028: Reset asserted mid-movement shall override all other activity on that edge; movement restarts only after a fresh debounce interval following reset release.

Verification
REQ-029: Scenario: reset, then ena=1, btn_right held -> moving=1 and dir=1 by cycle 19, and p_x steps 270,274,278,... once every 4 cycles.
REQ-030: Scenario: btn_left pulse 10 cycles wide -> debounced level never changes, p_x stays 270, moving stays 0.
REQ-031: Scenario: hold btn_left long from p_x=270 -> p_x decreases to 2, then 0, then stays 0 (no wrap to 4094); repeat with right from 538 -> 540, then holds.
REQ-032: Scenario: both buttons held -> state IDLE, p_x constant, dir keeps its prior value.
REQ-033: Scenario: ena dropped while moving right -> state IDLE next cycle, p_x frozen; ena raised with button still held -> movement resumes at the next tick with no re-debounce.
REQ-034: Scenario: rst pulsed while p_x=400 and moving -> next cycle p_x=270, moving=0, dir=0; a held button resumes movement only after 2+16 cycles.

Source files
------------

// File: rtl/player_move.sv
// Paddle mover: synchronizes and debounces two buttons, then steps the paddle x
// coordinate left/right on a free-running movement tick, clamped to [X_MIN, X_MAX].
module player_move #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned MOVE_DIV        = 4,
    parameter int unsigned STEP            = 4,
    parameter int unsigned X_MIN           = 0,
    parameter int unsigned X_MAX           = 540,
    parameter int unsigned X_INIT          = 270
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [11:0] p_x,
    output logic        moving,
    output logic        dir
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TK_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TK_W-1:0] TK_LAST  = TK_W'(MOVE_DIV - 1);
    localparam logic [12:0]     STEP_W   = 13'(STEP);
    localparam logic [12:0]     LEFT_LIM = 13'(X_MIN + STEP);
    localparam logic [12:0]     XMAX_W   = 13'(X_MAX);
    localparam logic [11:0]     STEP_P   = 12'(STEP);
    localparam logic [11:0]     XMIN_P   = 12'(X_MIN);
    localparam logic [11:0]     XMAX_P   = 12'(X_MAX);
    localparam logic [11:0]     XINIT_P  = 12'(X_INIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    // Bit 0 is the left button, bit 1 the right button throughout.
    logic [1:0]      r_meta;
    logic [1:0]      r_sync;
    logic [1:0]      r_deb;
    logic [DB_W-1:0] r_db_cnt [2];
    logic [TK_W-1:0] r_tick_cnt;
    state_t          r_state;
    logic [11:0]     r_p_x;
    logic            r_dir;
    logic            w_tick;
    logic [12:0]     w_px_ext;

    assign w_tick   = (r_tick_cnt == TK_LAST);
    assign w_px_ext = {1'b0, r_p_x};
    assign p_x      = r_p_x;
    assign dir      = r_dir;
    assign moving   = (r_state != IDLE);

    // Two-flop synchronizer for the raw buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 2'b00;
            r_sync <= 2'b00;
        end else begin
            r_meta <= {btn_right, btn_left};
            r_sync <= r_meta;
        end
    end

    // Per-button debouncer: accept a new level after DEBOUNCE_CYCLES disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync[i] == r_deb[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_deb[i]    <= r_sync[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Free-running movement tick, independent of ena.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TK_W'(1);
        end
    end

    // Direction FSM and position update; movement uses the pre-edge state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_dir   <= 1'b0;
            r_p_x   <= XINIT_P;
        end else begin
            if (!ena || (r_deb[0] == r_deb[1])) begin
                r_state <= IDLE;
            end else if (r_deb[0]) begin
                r_state <= LEFT;
                r_dir   <= 1'b0;
            end else begin
                r_state <= RIGHT;
                r_dir   <= 1'b1;
            end

            if (ena && w_tick) begin
                case (r_state)
                    LEFT:    r_p_x <= (w_px_ext < LEFT_LIM) ? XMIN_P : r_p_x - STEP_P;
                    RIGHT:   r_p_x <= ((w_px_ext + STEP_W) > XMAX_W) ? XMAX_P : r_p_x + STEP_P;
                    default: r_p_x <= r_p_x;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_player_move.sv
// Bench for player_move: directed segment table, clamp and reset sequences, and a
// randomized run, all checked every cycle against a history-based reference model.
module tb_player_move;

    localparam int unsigned DB    = 16;
    localparam int unsigned DIV   = 4;
    localparam int unsigned STP   = 4;
    localparam int unsigned XMIN  = 0;
    localparam int unsigned XMAX  = 540;
    localparam int unsigned XINIT = 270;
    localparam int          HMAX  = 16384;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic [11:0] p_x;
    logic        moving;
    logic        dir;

    int errors = 0;
    int checks = 0;

    player_move #(
        .DEBOUNCE_CYCLES(DB), .MOVE_DIV(DIV), .STEP(STP),
        .X_MIN(XMIN), .X_MAX(XMAX), .X_INIT(XINIT)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .btn_left(btn_left), .btn_right(btn_right),
        .p_x(p_x), .moving(moving), .dir(dir)
    );

    always #5 clk = ~clk;

    // Reference model: m_mode 0 = still, 1 = going left, 2 = going right.
    int m_px;
    int m_mode;
    bit m_dir;
    bit m_deb [2];
    int m_n;
    bit raw_at [2][HMAX];

    function automatic bit sync_seen(input int b, input int n);
        return (n >= 3) ? raw_at[b][n-2] : 1'b0;
    endfunction

    // A button's accepted level flips once its last DB synchronized samples all disagree.
    function automatic bit flips(input int b, input int n, input bit cur);
        if (n < int'(DB)) return 1'b0;
        for (int j = 0; j < int'(DB); j++) begin
            if (sync_seen(b, n - j) == cur) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge(input bit r_i, input bit e_i, input bit l_i, input bit rr_i);
        if (r_i) begin
            m_px = XINIT; m_mode = 0; m_dir = 1'b0;
            m_deb[0] = 1'b0; m_deb[1] = 1'b0; m_n = 0;
        end else begin
            m_n++;
            if (e_i && (m_n % int'(DIV) == 0)) begin
                if (m_mode == 1) m_px = (m_px - int'(STP) < int'(XMIN)) ? int'(XMIN) : m_px - int'(STP);
                if (m_mode == 2) m_px = (m_px + int'(STP) > int'(XMAX)) ? int'(XMAX) : m_px + int'(STP);
            end
            if (!e_i || m_deb[0] == m_deb[1]) m_mode = 0;
            else if (m_deb[0]) begin m_mode = 1; m_dir = 1'b0; end
            else begin m_mode = 2; m_dir = 1'b1; end
            raw_at[0][m_n] = l_i;
            raw_at[1][m_n] = rr_i;
            for (int b = 0; b < 2; b++) begin
                if (flips(b, m_n, m_deb[b])) m_deb[b] = ~m_deb[b];
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance model and DUT, compare shortly after the edge.
    task automatic step(input bit r_i, input bit e_i, input bit l_i, input bit rr_i);
        rst = r_i; ena = e_i; btn_left = l_i; btn_right = rr_i;
        @(posedge clk);
        model_edge(r_i, e_i, l_i, rr_i);
        #1;
        chk("px", int'(p_x), m_px);
        chk("moving", int'(moving), (m_mode != 0) ? 1 : 0);
        chk("dir", int'(dir), int'(m_dir));
        @(negedge clk);
    endtask

    typedef struct {
        bit    rst;
        bit    ena;
        bit    l;
        bit    r;
        int    ncyc;
        int    px;
        bit    mv;
        bit    dr;
        string name;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input bit r_i, input bit e_i, input bit l_i, input bit rr_i,
                                input int n, input int px, input bit mv, input bit dr,
                                input string nm);
        vec_t v;
        v.rst = r_i; v.ena = e_i; v.l = l_i; v.r = rr_i; v.ncyc = n;
        v.px = px; v.mv = mv; v.dr = dr; v.name = nm;
        return v;
    endfunction

    initial begin
        int last_px;
        int before_edge;
        bit seen;
        bit l_r, r_r, e_r, rs_r;
        int len;

        // Edge numbers after reset: tick edges are multiples of 4.
        tbl[0]  = mk(1, 0, 0, 0,  1, 270, 0, 0, "reset");
        tbl[1]  = mk(0, 1, 0, 1, 18, 270, 0, 0, "right_debouncing");
        tbl[2]  = mk(0, 1, 0, 1,  1, 270, 1, 1, "right_enter");
        tbl[3]  = mk(0, 1, 0, 1,  5, 278, 1, 1, "right_steps");
        tbl[4]  = mk(0, 0, 0, 1,  1, 278, 0, 1, "ena_drop");
        tbl[5]  = mk(0, 0, 0, 1,  4, 278, 0, 1, "ena_frozen");
        tbl[6]  = mk(0, 1, 0, 1,  1, 278, 1, 1, "ena_resume");
        tbl[7]  = mk(0, 1, 0, 1,  2, 282, 1, 1, "resume_tick");
        tbl[8]  = mk(0, 1, 1, 1, 17, 298, 1, 1, "both_debouncing");
        tbl[9]  = mk(0, 1, 1, 1,  1, 298, 1, 1, "both_accepted");
        tbl[10] = mk(0, 1, 1, 1,  1, 298, 0, 1, "both_idle");
        tbl[11] = mk(0, 1, 1, 1,  8, 298, 0, 1, "both_hold");
        tbl[12] = mk(0, 1, 1, 0, 18, 298, 0, 1, "right_release_deb");
        tbl[13] = mk(0, 1, 1, 0,  1, 298, 1, 0, "left_enter");
        tbl[14] = mk(0, 1, 1, 0,  2, 294, 1, 0, "left_step");
        tbl[15] = mk(0, 1, 0, 0, 16, 278, 1, 0, "left_release_deb");
        tbl[16] = mk(0, 1, 0, 0,  3, 278, 0, 0, "left_stop");
        tbl[17] = mk(0, 1, 1, 0, 10, 278, 0, 0, "glitch_pulse");
        tbl[18] = mk(0, 1, 0, 0, 20, 278, 0, 0, "glitch_after");

        @(negedge clk);
        for (int i = 0; i < 19; i++) begin
            for (int c = 0; c < tbl[i].ncyc; c++) begin
                step(tbl[i].rst, tbl[i].ena, tbl[i].l, tbl[i].r);
            end
            chk({tbl[i].name, ".px"}, int'(p_x), tbl[i].px);
            chk({tbl[i].name, ".moving"}, int'(moving), int'(tbl[i].mv));
            chk({tbl[i].name, ".dir"}, int'(dir), int'(tbl[i].dr));
        end

        // Left clamp: 270 steps down to 2, then clamps to 0 and stays.
        step(1, 0, 0, 0);
        seen = 1'b0; last_px = int'(p_x); before_edge = -1;
        for (int k = 0; k < 400; k++) begin
            step(0, 1, 1, 0);
            if (!seen && p_x == 12'd0) begin seen = 1'b1; before_edge = last_px; end
            last_px = int'(p_x);
        end
        chk("left_clamp_final", int'(p_x), 0);
        chk("left_clamp_prev", before_edge, 2);

        // Right clamp: 270 steps up to 538, then clamps to 540 and stays.
        step(1, 0, 0, 0);
        seen = 1'b0; last_px = int'(p_x); before_edge = -1;
        for (int k = 0; k < 400; k++) begin
            step(0, 1, 0, 1);
            if (!seen && p_x == 12'd540) begin seen = 1'b1; before_edge = last_px; end
            last_px = int'(p_x);
        end
        chk("right_clamp_final", int'(p_x), 540);
        chk("right_clamp_prev", before_edge, 538);

        // Reset in the middle of a rightward move, button still held.
        step(1, 0, 0, 0);
        for (int k = 0; k < 200 && p_x < 12'd400; k++) step(0, 1, 0, 1);
        chk("reached_400", (p_x >= 12'd400) ? 1 : 0, 1);
        chk("moving_before_rst", int'(moving), 1);
        step(1, 1, 0, 1);
        chk("rst_px", int'(p_x), 270);
        chk("rst_moving", int'(moving), 0);
        chk("rst_dir", int'(dir), 0);
        for (int k = 0; k < 18; k++) step(0, 1, 0, 1);
        chk("post_rst_wait", int'(moving), 0);
        step(0, 1, 0, 1);
        chk("post_rst_move", int'(moving), 1);
        chk("post_rst_dir", int'(dir), 1);

        // Randomized segments against the model.
        for (int s = 0; s < 150; s++) begin
            l_r  = 1'($urandom_range(0, 1));
            r_r  = 1'($urandom_range(0, 1));
            e_r  = ($urandom_range(0, 7) != 0);
            rs_r = ($urandom_range(0, 39) == 0);
            len  = int'($urandom_range(1, 40));
            if (rs_r) step(1, e_r, l_r, r_r);
            for (int c = 0; c < len; c++) step(0, e_r, l_r, r_r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
